// File: rtl/ita_job_arbiter.sv
// ita_job_arbiter: round-robin sharing of one ITA accelerator among NumReq job requesters.
// Optional start-to-busy watchdog is compiled in with `define ITA_ARB_TIMEOUT_EN.
module ita_job_arbiter #(
    parameter  int NumReq        = 2,
    parameter  int CfgW          = 64,
    parameter  int TimeoutCycles = 1024,
    localparam int OwnW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      req_valid_i,
    output logic [NumReq-1:0]      req_ready_o,
    input  logic [NumReq*CfgW-1:0] req_cfg_i,
    output logic [CfgW-1:0]        ita_cfg_o,
    output logic                   ita_start_o,
    input  logic                   ita_busy_i,
    output logic [OwnW-1:0]        owner_o,
    output logic                   owner_valid_o,
    output logic [NumReq-1:0]      done_o,
    output logic                   err_o,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } state_e;

    state_e          state_q;
    logic [OwnW-1:0] rr_ptr_q;
    logic [OwnW-1:0] win_idx;
    logic [OwnW:0]   cand;
    logic            win_found;
    logic            grant;
    logic [CfgW-1:0] win_cfg;

    assign state_o = state_q;

    // First valid requester at or above rr_ptr_q, wrapping; cand is one bit wider so the
    // sum never overflows before the explicit wrap for non-power-of-two NumReq.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = {1'b0, rr_ptr_q} + (OwnW + 1)'(k);
            if (cand >= (OwnW + 1)'(NumReq)) cand = cand - (OwnW + 1)'(NumReq);
            if (!win_found && req_valid_i[cand[OwnW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[OwnW-1:0];
            end
        end
    end

    always_comb begin
        win_cfg = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (win_idx == OwnW'(k)) win_cfg = req_cfg_i[k*CfgW +: CfgW];
        end
    end

    // Handshake: a job transfers on the clock edge where req_valid_i[i] and req_ready_o[i]
    // are both high. Ready is offered only in IDLE with ITA idle, to at most one requester.
    assign grant       = (state_q == IDLE) && !ita_busy_i && win_found;
    assign req_ready_o = (grant && !rst_i) ? (NumReq'(1) << win_idx) : '0;

`ifdef ITA_ARB_TIMEOUT_EN
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [CntW-1:0] wd_cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = |TimeoutCycles;
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            ita_cfg_o     <= '0;
            owner_o       <= '0;
            ita_start_o   <= 1'b0;
            owner_valid_o <= 1'b0;
            done_o        <= '0;
`ifdef ITA_ARB_TIMEOUT_EN
            wd_cnt_q      <= '0;
            err_o         <= 1'b0;
`endif
        end else begin
            ita_start_o <= 1'b0;
            done_o      <= '0;
`ifdef ITA_ARB_TIMEOUT_EN
            err_o       <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        ita_cfg_o     <= win_cfg;
                        owner_o       <= win_idx;
                        ita_start_o   <= 1'b1;
                        owner_valid_o <= 1'b1;
                        state_q       <= START;
                    end
                end
                START: begin
                    state_q <= WAIT_BUSY;
`ifdef ITA_ARB_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (ita_busy_i) begin
                        state_q <= RUN;
`ifdef ITA_ARB_TIMEOUT_EN
                    end else if (wd_cnt_q == CntW'(TimeoutCycles - 1)) begin
                        err_o   <= 1'b1;
                        done_o  <= NumReq'(1) << owner_o;
                        state_q <= DONE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CntW'(1);
`endif
                    end
                end
                RUN: begin
                    if (!ita_busy_i) begin
                        done_o  <= NumReq'(1) << owner_o;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    owner_valid_o <= 1'b0;
                    rr_ptr_q      <= (owner_o == OwnW'(NumReq - 1)) ? '0 : owner_o + OwnW'(1);
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ita_job_arbiter.sv
// Self-checking bench for ita_job_arbiter: random jobs against a transaction-level model of
// round-robin grants, with the bench acting as the ITA busy responder.
module tb_ita_job_arbiter;

    localparam int N  = 3;
    localparam int CW = 16;
    localparam int TO = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*CW-1:0] req_cfg;
    logic [CW-1:0]   ita_cfg;
    logic            ita_start;
    logic            ita_busy;
    logic [1:0]      owner;
    logic            owner_valid;
    logic [N-1:0]    done;
    logic            err;
    logic [2:0]      dbg_state;

    logic [CW-1:0]   cfg_arr [N];
    logic [1:0]      exp_q [$];
    int              checks = 0;
    int              errors = 0;
    int              rr_model = 0;

    ita_job_arbiter #(.NumReq(N), .CfgW(CW), .TimeoutCycles(TO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_cfg_i    (req_cfg),
        .ita_cfg_o    (ita_cfg),
        .ita_start_o  (ita_start),
        .ita_busy_i   (ita_busy),
        .owner_o      (owner),
        .owner_valid_o(owner_valid),
        .done_o       (done),
        .err_o        (err),
        .state_o      (dbg_state)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference model: first valid requester scanning upward from the pointer, modulo N.
    function automatic int pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(rr_model + k) % N]) return (rr_model + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic drive_cfg(input int cfg0);
        for (int i = 0; i < N; i++) begin
            cfg_arr[i] = CW'($urandom);
            if (i == 0 && cfg0 >= 0) cfg_arr[0] = CW'(cfg0);
            req_cfg[i*CW +: CW] = cfg_arr[i];
        end
    endtask

    // driver: one complete job from grant to completion
    task automatic run_job(input logic [N-1:0] mask, input int idle_busy, input int wait_len,
                           input int busy_len, input int cfg0);
        int            w;
        logic [CW-1:0] exp_cfg;
        drive_cfg(cfg0);
        req_valid = mask;
        if (idle_busy > 0) begin
            ita_busy = 1'b1;
            repeat (idle_busy) begin
                settle();
                check("ready_foreign_busy", req_ready, 0);
                check("start_foreign_busy", ita_start, 0);
                step();
            end
            ita_busy = 1'b0;
        end
        settle();
        w = pick(mask);
        check("grant_ready", req_ready, onehot(w));
        exp_cfg = cfg_arr[w];
        exp_q.push_back(2'(w));
        step();
        if ($urandom_range(0, 1) == 1) req_valid = '0;
        drive_cfg(-1);
        settle();
        check("start_pulse", ita_start, 1);
        check("owner", owner, w);
        check("cfg_latched", ita_cfg, exp_cfg);
        check("owner_valid_start", owner_valid, 1);
        check("ready_in_start", req_ready, 0);
        step();
        check("start_one_cycle", ita_start, 0);
        repeat (wait_len) begin
            settle();
            check("wait_no_done", done, 0);
            check("wait_no_err", err, 0);
            check("wait_cfg_stable", ita_cfg, exp_cfg);
            step();
        end
        ita_busy = 1'b1;
        repeat (busy_len) begin
            step();
            check("run_owner_valid", owner_valid, 1);
            check("run_no_done", done, 0);
            check("run_no_ready", req_ready, 0);
        end
        ita_busy = 1'b0;
        step();
        check("done_owner", done, onehot(int'(exp_q.pop_front())));
        check("done_owner_valid", owner_valid, 1);
        check("done_owner_stable", owner, w);
        check("done_no_err", err, 0);
        step();
        check("done_one_cycle", done, 0);
        check("idle_owner_valid", owner_valid, 0);
        check("idle_owner_hold", owner, w);
        check("idle_cfg_hold", ita_cfg, exp_cfg);
        rr_model = (w + 1) % N;
    endtask

    task automatic reset_mid_job();
        drive_cfg(-1);
        req_valid = 3'b010;
        settle();
        check("abort_ready", req_ready, 3'b010);
        step();
        check("abort_owner", owner, 1);
        step();
        ita_busy = 1'b1;
        step();
        step();
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_start", ita_start, 0);
        check("rst_owner_valid", owner_valid, 0);
        check("rst_owner", owner, 0);
        check("rst_cfg", ita_cfg, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        ita_busy = 1'b0;
        #1;
        check("rst_ready_gated", req_ready, 0);
        step();
        step();
        check("rst_no_done", done, 0);
        rst_i    = 1'b0;
        rr_model = 0;
    endtask

    task automatic watchdog_job();
        int w;
        drive_cfg(-1);
        req_valid = 3'b111;
        settle();
        w = pick(3'b111);
        check("wd_grant", req_ready, onehot(w));
        step();
        step();
`ifdef ITA_ARB_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            step();
            check("wd_no_err_early", err, 0);
            check("wd_no_done_early", done, 0);
        end
        step();
        check("wd_err_pulse", err, 1);
        check("wd_done", done, onehot(w));
        step();
        check("wd_err_one_cycle", err, 0);
        check("wd_done_one_cycle", done, 0);
`else
        repeat (5 * TO) begin
            step();
            check("hold_no_err", err, 0);
            check("hold_no_done", done, 0);
            check("hold_owner_valid", owner_valid, 1);
        end
        ita_busy = 1'b1;
        step();
        ita_busy = 1'b0;
        step();
        check("hold_done", done, onehot(w));
        step();
`endif
        rr_model = (w + 1) % N;
    endtask

    initial begin
        rst_i     = 1'b1;
        req_valid = '0;
        ita_busy  = 1'b0;
        req_cfg   = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_ready", req_ready, 0);
        check("reset_start", ita_start, 0);
        check("reset_owner_valid", owner_valid, 0);
        check("reset_owner", owner, 0);
        check("reset_cfg", ita_cfg, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        rst_i = 1'b0;

        run_job(3'b001, 0, 0, 10, 'hA5);
        repeat (6) run_job(3'b111, 0, $urandom_range(0, 3), $urandom_range(1, 4), -1);
        run_job(3'b010, 3, 0, 2, -1);
        run_job(3'b011, 0, 1, 1, -1);
        reset_mid_job();
        run_job(3'b011, 0, 0, 3, -1);
        watchdog_job();
        run_job(3'b111, 0, 0, 2, -1);
        run_job(3'b100, 0, 1, 2, -1);
        run_job(3'b101, 0, 0, 1, -1);
        repeat (25) begin
            run_job(N'($urandom_range(1, 7)), $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom_range(1, 5), -1);
        end
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
